cla_addsub_pipe: RTL

CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

---
 rtl/cla_addsub_pipe_if.sv | 62 ++++++
 rtl/cla_addsub_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if -- operand/result bus of the pipelined CLA adder/subtractor.
//
// Purpose: groups the input handshake, operands, output handshake, result
// and flags into one bundle. The master modport drives operands and
// out_ready. The slave modport (the adder) drives in_ready, the result and
// the flags.
//
// Handshake: a beat moves on the input side when in_valid && in_ready, and
// on the output side when out_valid && out_ready. Senders keep their payload
// steady while valid is high and the beat has not moved yet. in_valid must
// not wait for in_ready.
//
// Ports (signals):
//   in_valid, in_ready        input-side handshake
//   x, y [WIDTH]              operands
//   op                        0 = add, 1 = subtract
//   cin                       carry-in (add only)
//   sat                       saturate on signed overflow (only with CLA_ADDSUB_SAT_EN)
//   out_valid, out_ready      output-side handshake
//   z [WIDTH]                 result
//   sign, zero, carry, parity, overflow   result flags
//
// Optional feature macro: CLA_ADDSUB_SAT_EN (adds the sat signal).
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             op;
    logic             cin;
`ifdef CLA_ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             sign;
    logic             zero;
    logic             carry;
    logic             parity;
    logic             overflow;

    modport master (
        output in_valid, x, y, op, cin,
`ifdef CLA_ADDSUB_SAT_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, z, sign, zero, carry, parity, overflow
    );

    modport slave (
        input  in_valid, x, y, op, cin,
`ifdef CLA_ADDSUB_SAT_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, z, sign, zero, carry, parity, overflow
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe -- pipelined add/subtract built from 4-bit carry-lookahead
// groups.
//
// Purpose: computes z = x + y + cin (op = 0) or z = x + ~y + 1 (op = 1),
// modulo 2^WIDTH. Flags are produced with z. The design has STAGES register
// stages. Stage k adds groups k*G .. (k+1)*G-1, where G = WIDTH/(4*STAGES).
// It registers the sum bits so far, the group carry-out and the operand bits
// that later stages still need. Each stage has an elastic valid bit, so a
// stall at the output backs up stage by stage and no operand set is lost.
//
// Parameters: WIDTH (multiple of 4, >= 8), STAGES (must divide WIDTH/4).
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset. It clears all valids, z and flags.
//   bus   cla_addsub_pipe_if.slave. This port carries operands, handshakes,
//         the result and the flags.
//
// Optional feature macro: CLA_ADDSUB_SAT_EN. When defined, bus.sat clamps z
// on signed overflow. overflow and carry still describe the wrapped sum.
module cla_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    cla_addsub_pipe_if.slave bus
);
    localparam int G   = WIDTH / (4 * STAGES);
    localparam int MSB = WIDTH - 1;

    // 4-bit lookahead group: all four carries in two-level form.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, p ^ {c3, c2, c1, ci}};
    endfunction

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] valid_feed;

    logic [WIDTH-1:0] z_q;
    logic             sign_q, zero_q, carry_q, parity_q, ovf_q;

    // Stage k may load when it is empty, or when the stage after it moves
    // on. Unrolled, this means: out_ready, or some stage from k to the end
    // is empty. Evaluating that directly avoids a combinational chain
    // through the load vector.
    for (genvar k = 0; k < STAGES; k++) begin : g_load
        localparam logic [STAGES-1:0] LOWER = STAGES'((1 << k) - 1);
        assign load[k] = bus.out_ready | ~&(valid | LOWER);
    end

    // Valid source for each stage: in_valid for stage 0, previous stage otherwise.
    assign valid_feed = STAGES'({valid, bus.in_valid});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) valid[k] <= valid_feed[k];
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid[STAGES-1];
    assign bus.z         = z_q;
    assign bus.sign      = sign_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.parity    = parity_q;
    assign bus.overflow  = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = 4 * G * k;   // first bit this stage adds
        localparam int HI = LO + 4 * G;  // first bit left for later stages

        logic [WIDTH-1:LO] x_in;         // effective operands, unconsumed part
        logic [WIDTH-1:LO] y_in;
        logic              c_in;
`ifdef CLA_ADDSUB_SAT_EN
        logic              sat_in;
`endif
        logic [4*G-1:0]    slice;
        logic              c_out;
        logic [HI-1:0]     sum_acc;      // sum bits produced so far

        if (k == 0) begin : g_head
            // Subtract is add with y inverted and carry-in forced to 1.
            assign x_in    = bus.x;
            assign y_in    = bus.op ? ~bus.y : bus.y;
            assign c_in    = bus.op | bus.cin;
`ifdef CLA_ADDSUB_SAT_EN
            assign sat_in  = bus.sat;
`endif
            assign sum_acc = slice;
        end else begin : g_tail
            assign x_in    = g_stage[k-1].g_reg.x_q;
            assign y_in    = g_stage[k-1].g_reg.y_q;
            assign c_in    = g_stage[k-1].g_reg.c_q;
`ifdef CLA_ADDSUB_SAT_EN
            assign sat_in  = g_stage[k-1].g_reg.sat_q;
`endif
            assign sum_acc = {slice, g_stage[k-1].g_reg.s_q};
        end

        // Carries ripple between the groups of this stage.
        always_comb begin : cla_chain
            logic [4:0] r;
            logic       c;
            c     = c_in;
            r     = '0;
            slice = '0;
            for (int j = 0; j < G; j++) begin
                r = cla4(x_in[LO + 4*j +: 4], y_in[LO + 4*j +: 4], c);
                slice[4*j +: 4] = r[3:0];
                c = r[4];
            end
            c_out = c;
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:HI] x_q;
            logic [WIDTH-1:HI] y_q;
            logic [HI-1:0]     s_q;
            logic              c_q;
`ifdef CLA_ADDSUB_SAT_EN
            logic              sat_q;
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_q   <= '0;
                    y_q   <= '0;
                    s_q   <= '0;
                    c_q   <= 1'b0;
`ifdef CLA_ADDSUB_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (load[k]) begin
                    x_q   <= x_in[WIDTH-1:HI];
                    y_q   <= y_in[WIDTH-1:HI];
                    s_q   <= sum_acc;
                    c_q   <= c_out;
`ifdef CLA_ADDSUB_SAT_EN
                    sat_q <= sat_in;
`endif
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] z_nx;
            logic             ovf;

            // Signed overflow: effective operands agree in sign and the
            // wrapped sum does not.
            always_comb begin
                ovf  = (x_in[MSB] == y_in[MSB]) && (sum_acc[MSB] != x_in[MSB]);
                z_nx = sum_acc;
`ifdef CLA_ADDSUB_SAT_EN
                // Both operands negative means the true result fell below the range.
                if (sat_in && ovf) begin
                    z_nx = x_in[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    z_q      <= '0;
                    sign_q   <= 1'b0;
                    zero_q   <= 1'b0;
                    carry_q  <= 1'b0;
                    parity_q <= 1'b0;
                    ovf_q    <= 1'b0;
                end else if (load[k]) begin
                    z_q      <= z_nx;
                    sign_q   <= z_nx[MSB];
                    zero_q   <= (z_nx == '0);
                    carry_q  <= c_out;
                    parity_q <= ~^z_nx;
                    ovf_q    <= ovf;
                end
            end
        end
    end
endmodule
